// File: rtl/stop_watch_cu.sv
// Stopwatch control unit: merges buttons and UART commands into run/clear/lap events and sequences STOP/RUN/CLEAR.
// Optional lap feature (snapshot display, lap_hold) is built only when STOPWATCH_LAP_EN is defined.
module stop_watch_cu #(
  parameter int MSEC_W       = 7,
  parameter int TIME_W       = 6,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_run,
  input  logic              btn_clear,
  input  logic              btn_lap,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_code,
  input  logic [MSEC_W-1:0] i_msec,
  input  logic [TIME_W-1:0] i_sec,
  input  logic [TIME_W-1:0] i_min,
  input  logic [TIME_W-1:0] i_hour,
  output logic              run_stop,
  output logic              clear,
  output logic              lap_hold,
  output logic [1:0]        o_state,
  output logic [MSEC_W-1:0] o_msec,
  output logic [TIME_W-1:0] o_sec,
  output logic [TIME_W-1:0] o_min,
  output logic [TIME_W-1:0] o_hour
);

  localparam int CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } state_t;

`ifdef STOPWATCH_LAP_EN
  localparam int NBTN = 3;
  logic [NBTN-1:0] w_btn_in;
  assign w_btn_in = {btn_lap, btn_clear, btn_run};
`else
  localparam int NBTN = 2;
  logic [NBTN-1:0] w_btn_in;
  logic            w_unused_lap;
  assign w_btn_in     = {btn_clear, btn_run};
  assign w_unused_lap = btn_lap;
`endif

  logic [NBTN-1:0] r_btn_sync;
  logic [NBTN-1:0] r_btn_dly;
  logic [NBTN-1:0] w_btn_ev;
  logic            r_cmd_valid;
  logic [1:0]      r_cmd_code;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_btn_sync  <= '0;
      r_btn_dly   <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= 2'b00;
    end else begin
      r_btn_sync  <= w_btn_in;
      r_btn_dly   <= r_btn_sync;
      r_cmd_valid <= cmd_valid;
      r_cmd_code  <= cmd_code;
    end
  end

  // Rising edge only, so a held button produces a single event.
  assign w_btn_ev = r_btn_sync & ~r_btn_dly;

  logic w_ev_run;
  logic w_ev_clear;
  logic w_ev_lap;

  assign w_ev_run   = w_btn_ev[0] | (r_cmd_valid && (r_cmd_code == 2'b00));
  assign w_ev_clear = w_btn_ev[1] | (r_cmd_valid && (r_cmd_code == 2'b01));
`ifdef STOPWATCH_LAP_EN
  assign w_ev_lap   = w_btn_ev[2] | (r_cmd_valid && (r_cmd_code == 2'b10));
`else
  assign w_ev_lap   = 1'b0;
`endif

  state_t          r_state;
  state_t          w_state_next;
  logic [CNT_W-1:0] r_clr_cnt;
  logic [CNT_W-1:0] w_clr_cnt_next;
  logic            r_lap_hold;
  logic            w_lap_hold_next;
  logic            w_snap;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_STOP;
      r_clr_cnt  <= '0;
      r_lap_hold <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_clr_cnt  <= w_clr_cnt_next;
      r_lap_hold <= w_lap_hold_next;
    end
  end

  // Priority clear > run > lap; losing events in the same cycle are dropped.
  always_comb begin
    w_state_next    = r_state;
    w_clr_cnt_next  = r_clr_cnt;
    w_lap_hold_next = r_lap_hold;
    w_snap          = 1'b0;
    case (r_state)
      ST_STOP: begin
        if (w_ev_clear) begin
          w_state_next    = ST_CLEAR;
          w_clr_cnt_next  = '0;
          w_lap_hold_next = 1'b0;
        end else if (w_ev_run) begin
          w_state_next = ST_RUN;
        end else if (w_ev_lap) begin
          w_lap_hold_next = 1'b0;
        end
      end
      ST_RUN: begin
        if (w_ev_run) begin
          w_state_next = ST_STOP;
        end else if (w_ev_lap) begin
          w_lap_hold_next = ~r_lap_hold;
          w_snap          = ~r_lap_hold;
        end
      end
      ST_CLEAR: begin
        if (r_clr_cnt == CNT_LAST) begin
          w_state_next   = ST_STOP;
          w_clr_cnt_next = '0;
        end else begin
          w_clr_cnt_next = r_clr_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next   = ST_STOP;
        w_clr_cnt_next = '0;
      end
    endcase
  end

  assign run_stop = (r_state == ST_RUN);
  assign clear    = (r_state == ST_CLEAR);
  assign o_state  = r_state;

  logic [MSEC_W-1:0] r_live_msec;
  logic [TIME_W-1:0] r_live_sec;
  logic [TIME_W-1:0] r_live_min;
  logic [TIME_W-1:0] r_live_hour;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_live_msec <= '0;
      r_live_sec  <= '0;
      r_live_min  <= '0;
      r_live_hour <= '0;
    end else begin
      r_live_msec <= i_msec;
      r_live_sec  <= i_sec;
      r_live_min  <= i_min;
      r_live_hour <= i_hour;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [MSEC_W-1:0] r_snap_msec;
  logic [TIME_W-1:0] r_snap_sec;
  logic [TIME_W-1:0] r_snap_min;
  logic [TIME_W-1:0] r_snap_hour;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_snap_msec <= '0;
      r_snap_sec  <= '0;
      r_snap_min  <= '0;
      r_snap_hour <= '0;
    end else if (w_snap) begin
      r_snap_msec <= i_msec;
      r_snap_sec  <= i_sec;
      r_snap_min  <= i_min;
      r_snap_hour <= i_hour;
    end
  end

  assign lap_hold = r_lap_hold;
  assign o_msec   = r_lap_hold ? r_snap_msec : r_live_msec;
  assign o_sec    = r_lap_hold ? r_snap_sec  : r_live_sec;
  assign o_min    = r_lap_hold ? r_snap_min  : r_live_min;
  assign o_hour   = r_lap_hold ? r_snap_hour : r_live_hour;
`else
  assign lap_hold = 1'b0;
  assign o_msec   = r_live_msec;
  assign o_sec    = r_live_sec;
  assign o_min    = r_live_min;
  assign o_hour   = r_live_hour;
`endif

endmodule

// File: tb/tb_stop_watch_cu.sv
// Scoreboard bench for stop_watch_cu: stimulus queues expected outputs tagged with a clock edge count,
// a negedge monitor pops and compares them. Lap expectations follow STOPWATCH_LAP_EN.
module tb_stop_watch_cu;

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_CLR  = 2'd2;
`ifdef STOPWATCH_LAP_EN
  localparam logic LAP = 1'b1;
`else
  localparam logic LAP = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       btn_run, btn_clear, btn_lap, cmd_valid;
  logic [1:0] cmd_code;
  logic [6:0] i_msec;
  logic [5:0] i_sec, i_min, i_hour;
  logic       run_stop, clear, lap_hold;
  logic [1:0] o_state;
  logic [6:0] o_msec;
  logic [5:0] o_sec, o_min, o_hour;

  stop_watch_cu #(.MSEC_W(7), .TIME_W(6), .CLEAR_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .btn_run(btn_run), .btn_clear(btn_clear), .btn_lap(btn_lap),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .i_msec(i_msec), .i_sec(i_sec), .i_min(i_min), .i_hour(i_hour),
    .run_stop(run_stop), .clear(clear), .lap_hold(lap_hold), .o_state(o_state),
    .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [1:0] st;
    logic       rs;
    logic       cl;
    logic       lh;
    bit         ct;
    logic [6:0] ms;
    logic [5:0] s;
    logic [5:0] mn;
    logic [5:0] h;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic void exp_full(int dc, string nm, logic [1:0] st, logic rs, logic cl, logic lh,
                                   bit ct, logic [6:0] ms, logic [5:0] s, logic [5:0] mn, logic [5:0] h);
    exp_t e;
    e.cyc = cyc + dc; e.name = nm; e.st = st; e.rs = rs; e.cl = cl; e.lh = lh;
    e.ct = ct; e.ms = ms; e.s = s; e.mn = mn; e.h = h;
    q.push_back(e);
  endfunction

  function automatic void exp_ctl(int dc, string nm, logic [1:0] st, logic rs, logic cl, logic lh);
    exp_full(dc, nm, st, rs, cl, lh, 1'b0, 7'd0, 6'd0, 6'd0, 6'd0);
  endfunction

  function automatic void exp_t4(int dc, string nm, logic [1:0] st, logic rs, logic cl, logic lh,
                                 logic [6:0] ms, logic [5:0] s, logic [5:0] mn, logic [5:0] h);
    exp_full(dc, nm, st, rs, cl, lh, 1'b1, ms, s, mn, h);
  endfunction

  // Monitor: compare every expectation due at this edge count.
  always @(negedge clk) begin
    int k;
    bit bad;
    k = 0;
    while (k < q.size()) begin
      if (q[k].cyc == cyc) begin
        checks++;
        bad = (o_state !== q[k].st) || (run_stop !== q[k].rs) || (clear !== q[k].cl) ||
              (lap_hold !== q[k].lh) ||
              (q[k].ct && ((o_msec !== q[k].ms) || (o_sec !== q[k].s) ||
                           (o_min !== q[k].mn) || (o_hour !== q[k].h)));
        if (bad) begin
          errors++;
          $display("FAIL %s edge=%0d got st=%0d rs=%0b cl=%0b lh=%0b t=%0d:%0d:%0d.%0d want st=%0d rs=%0b cl=%0b lh=%0b t=%0d:%0d:%0d.%0d (time %0s)",
                   q[k].name, cyc, o_state, run_stop, clear, lap_hold, o_hour, o_min, o_sec, o_msec,
                   q[k].st, q[k].rs, q[k].cl, q[k].lh, q[k].h, q[k].mn, q[k].s, q[k].ms,
                   q[k].ct ? "checked" : "ignored");
        end else begin
          $display("check %s edge=%0d st=%0d rs=%0b cl=%0b lh=%0b t=%0d:%0d:%0d.%0d ok",
                   q[k].name, cyc, o_state, run_stop, clear, lap_hold, o_hour, o_min, o_sec, o_msec);
        end
        q.delete(k);
      end else if (q[k].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s edge=%0d expectation missed, due at edge %0d", q[k].name, cyc, q[k].cyc);
        q.delete(k);
      end else begin
        k++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with every input high.
    reset = 1'b0; btn_run = 1'b1; btn_clear = 1'b1; btn_lap = 1'b1;
    cmd_valid = 1'b1; cmd_code = 2'b11;
    i_msec = 7'h7f; i_sec = 6'h3f; i_min = 6'h3f; i_hour = 6'h3f;
    exp_t4(1, "rst_e1", ST_STOP, 0, 0, 0, 7'd0, 6'd0, 6'd0, 6'd0);
    exp_t4(2, "rst_e2", ST_STOP, 0, 0, 0, 7'd0, 6'd0, 6'd0, 6'd0);
    tick(2);

    reset = 1'b1; btn_run = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
    cmd_valid = 1'b0; cmd_code = 2'b00;
    i_msec = 7'd0; i_sec = 6'd0; i_min = 6'd5; i_hour = 6'd1;
    exp_t4(1, "idle", ST_STOP, 0, 0, 0, 7'd0, 6'd0, 6'd5, 6'd1);
    tick(3);

    // Run toggle with a 1-cycle pulse, then stop.
    btn_run = 1'b1;
    exp_ctl(1, "run_lat", ST_STOP, 0, 0, 0);
    exp_ctl(2, "run_go", ST_RUN, 1, 0, 0);
    tick(1); btn_run = 1'b0; tick(3);
    btn_run = 1'b1;
    exp_ctl(1, "stop_lat", ST_RUN, 1, 0, 0);
    exp_ctl(2, "run_halt", ST_STOP, 0, 0, 0);
    tick(1); btn_run = 1'b0; tick(3);

    // Held 50 cycles: exactly one toggle.
    btn_run = 1'b1;
    exp_ctl(2, "hold_go", ST_RUN, 1, 0, 0);
    exp_ctl(25, "hold_mid", ST_RUN, 1, 0, 0);
    exp_ctl(50, "hold_end", ST_RUN, 1, 0, 0);
    tick(50); btn_run = 1'b0;
    exp_ctl(3, "hold_rel", ST_RUN, 1, 0, 0);
    tick(4);

    // Clear button is ignored while running.
    btn_clear = 1'b1;
    exp_ctl(2, "clr_run_a", ST_RUN, 1, 0, 0);
    exp_ctl(4, "clr_run_b", ST_RUN, 1, 0, 0);
    tick(1); btn_clear = 1'b0; tick(4);

    // UART run toggle stops.
    cmd_valid = 1'b1; cmd_code = 2'b00;
    exp_ctl(1, "cmd_lat", ST_RUN, 1, 0, 0);
    exp_ctl(2, "cmd_stop", ST_STOP, 0, 0, 0);
    tick(1); cmd_valid = 1'b0; tick(3);

    // UART clear: clear high exactly 4 cycles.
    cmd_valid = 1'b1; cmd_code = 2'b01;
    exp_ctl(1, "cclr_lat", ST_STOP, 0, 0, 0);
    for (int k = 2; k <= 5; k++) exp_ctl(k, "cclr_on", ST_CLR, 0, 1, 0);
    exp_ctl(6, "cclr_done", ST_STOP, 0, 0, 0);
    exp_ctl(7, "cclr_after", ST_STOP, 0, 0, 0);
    tick(1); cmd_valid = 1'b0; tick(7);

    // Run button and clear command together: clear wins, run dropped.
    btn_run = 1'b1; cmd_valid = 1'b1; cmd_code = 2'b01;
    for (int k = 2; k <= 5; k++) exp_ctl(k, "coin_clr", ST_CLR, 0, 1, 0);
    exp_ctl(6, "coin_done", ST_STOP, 0, 0, 0);
    exp_ctl(8, "coin_after", ST_STOP, 0, 0, 0);
    tick(1); btn_run = 1'b0; cmd_valid = 1'b0; tick(8);

    // Reserved command code is ignored.
    cmd_valid = 1'b1; cmd_code = 2'b11;
    exp_ctl(2, "rsv_a", ST_STOP, 0, 0, 0);
    exp_ctl(3, "rsv_b", ST_STOP, 0, 0, 0);
    tick(1); cmd_valid = 1'b0; tick(3);

    // Lap hold while running.
    btn_run = 1'b1;
    exp_ctl(2, "lap_run", ST_RUN, 1, 0, 0);
    tick(1); btn_run = 1'b0; tick(3);
    i_sec = 6'd12; i_msec = 7'd34;
    tick(1);
    btn_lap = 1'b1;
    exp_t4(1, "lap_lat", ST_RUN, 1, 0, 0, 7'd34, 6'd12, 6'd5, 6'd1);
    exp_t4(2, "lap_on", ST_RUN, 1, 0, LAP, 7'd34, 6'd12, 6'd5, 6'd1);
    tick(1); btn_lap = 1'b0; tick(1);
    i_msec = 7'd77; i_sec = 6'd40;
    exp_t4(1, "lap_frz1", ST_RUN, 1, 0, LAP, LAP ? 7'd34 : 7'd77, LAP ? 6'd12 : 6'd40, 6'd5, 6'd1);
    exp_t4(4, "lap_frz4", ST_RUN, 1, 0, LAP, LAP ? 7'd34 : 7'd77, LAP ? 6'd12 : 6'd40, 6'd5, 6'd1);
    tick(5);
    btn_lap = 1'b1;
    exp_t4(1, "unlap_lat", ST_RUN, 1, 0, LAP, LAP ? 7'd34 : 7'd77, LAP ? 6'd12 : 6'd40, 6'd5, 6'd1);
    exp_t4(2, "unlap", ST_RUN, 1, 0, 0, 7'd77, 6'd40, 6'd5, 6'd1);
    tick(1); btn_lap = 1'b0; tick(3);

    // Lap via UART, then reset mid-lap.
    cmd_valid = 1'b1; cmd_code = 2'b10;
    exp_ctl(2, "cmd_lap", ST_RUN, 1, 0, LAP);
    tick(1); cmd_valid = 1'b0; tick(2);
    reset = 1'b0;
    exp_t4(1, "rst_lap", ST_STOP, 0, 0, 0, 7'd0, 6'd0, 6'd0, 6'd0);
    tick(1); reset = 1'b1;
    exp_t4(1, "rst_lap_rel", ST_STOP, 0, 0, 0, 7'd77, 6'd40, 6'd5, 6'd1);
    tick(3);

    // Reset during clear cycle 2: no residual clear.
    cmd_valid = 1'b1; cmd_code = 2'b01;
    exp_ctl(2, "rc_c1", ST_CLR, 0, 1, 0);
    exp_ctl(3, "rc_c2", ST_CLR, 0, 1, 0);
    tick(1); cmd_valid = 1'b0; tick(2);
    reset = 1'b0;
    exp_t4(1, "rc_rst", ST_STOP, 0, 0, 0, 7'd0, 6'd0, 6'd0, 6'd0);
    tick(1); reset = 1'b1;
    exp_ctl(1, "rc_rel", ST_STOP, 0, 0, 0);
    exp_ctl(2, "rc_nores", ST_STOP, 0, 0, 0);
    exp_ctl(5, "rc_late", ST_STOP, 0, 0, 0);
    tick(7);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
